point_plotter: RTL and testbench
================================

Name: point_plotter

Overview:
- Consumer end of the projected-point stream: accepts (x, y, valid) screen points from the perspective projection stage.
- Buffers points in a small FIFO and writes them as pixels into a single-port frame-buffer BRAM write port.
- Performs a full-screen background clear at each frame start, then plots the buffered points.
- The projection stage has no backpressure, so this block absorbs bursts and drops points on overflow, reporting the drops.

Parameters:
- WIDTH, 320, screen width in pixels; valid x is 0..WIDTH-1.
- HEIGHT, 180, screen height in pixels; valid y is 0..HEIGHT-1.
- FIFO_DEPTH, 16, point FIFO entries (power of two).
- FG_COLOR, 8'hFF, pixel value written for a plotted point.
- BG_COLOR, 8'h00, pixel value written during clear.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- x_in  input  9  projected x
- y_in  input  8  projected y
- valid_in  input  1  point strobe, one point per cycle max
- frame_start_in  input  1  single-cycle pulse: begin new frame
- fb_addr_out  output  16  frame-buffer write address, y*WIDTH+x
- fb_data_out  output  8  frame-buffer write data
- fb_we_out  output  1  frame-buffer write enable
- busy_out  output  1  high while clearing
- overflow_out  output  1  sticky: a point was dropped because the FIFO was full
- drop_count_out  output  16  saturating count of dropped points (full FIFO or out of range)

Behaviour:
- Reset: state IDLE; FIFO empty. fb_addr_out=0, fb_data_out=0, fb_we_out=0, busy_out=0, overflow_out=0, drop_count_out=0.
- States and transitions:
  - IDLE: no writes; points are still accepted into the FIFO. frame_start_in -> CLEAR.
  - CLEAR: a clear counter runs 0..WIDTH*HEIGHT-1, one write per cycle (fb_we_out=1, data=BG_COLOR, addr=counter). busy_out=1. After address WIDTH*HEIGHT-1 is issued -> PLOT. The first clear write appears the cycle after frame_start_in is sampled.
  - PLOT: each cycle the FIFO is non-empty, pop one entry and issue one write (addr=y*WIDTH+x, data=FG_COLOR, we=1). When the FIFO is empty, fb_we_out=0. Remain in PLOT until the next frame_start_in.
- frame_start_in in any state, including mid-CLEAR:
  - FIFO is flushed, clear counter restarts at 0, overflow_out and drop_count_out clear to 0, next state CLEAR.
  - A valid_in in the same cycle is discarded and is not counted.
- Input acceptance (all states):
  - A point with x>=WIDTH or y>=HEIGHT is rejected and increments drop_count_out.
  - Otherwise the point is pushed if the FIFO is not full at the start of the cycle.
  - If the FIFO is full, the point is dropped, overflow_out is set, and drop_count_out is incremented, even if a pop occurs the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the occupancy unchanged.
- Latency: a point sampled on valid_in at edge N, in PLOT with an empty FIFO, produces fb_we_out high during cycle N+2. FIFO order is preserved.
- Points pushed during CLEAR are held and drained in order once PLOT is entered. They are never written before the clear completes.
- Outputs are registered. fb_addr_out and fb_data_out hold their last value while fb_we_out=0.
- Address arithmetic: 16-bit unsigned, y*WIDTH+x, no wrap for in-range inputs (max 57599).
- drop_count_out saturates at 16'hFFFF.
- Reset mid-CLEAR or mid-PLOT returns immediately to reset values; a partial clear is not resumed.

Decomposition:
- Shared package (e.g. graphics_pkg): SCREEN_WIDTH=320, SCREEN_HEIGHT=180, FB_ADDR_W=16, PIXEL_W=8, and a packed point_t typedef {y[7:0], x[8:0]}.
- One sub-module: point_fifo, a synchronous FIFO of point_t with push, pop, full, empty and flush.
- The FSM, range check, address generation and counters stay in point_plotter.

Test Plan:
- Reset, then frame_start_in pulse -> 57600 consecutive writes, addr 0..57599, data 0x00, busy_out=1 throughout. Then busy_out=0 and state PLOT with fb_we_out=0.
- In PLOT with an empty FIFO, point (x=10, y=5) at cycle N -> fb_we_out=1 at N+2 with addr=1610, data 0xFF, and exactly one write.
- During CLEAR, push 20 valid points -> 16 are accepted, overflow_out=1, drop_count_out=4. After the clear, 16 writes appear in arrival order and no write precedes clear address 57599.
- Points (319,179), (320,0) and (0,180) -> the first is written at addr 57599; the other two are rejected and drop_count_out=2.
- frame_start_in at clear address 1000 with 3 points queued -> FIFO flushed, counters zeroed, clear restarts at addr 0, and none of the 3 points is ever written.
- Back-to-back valid_in for 40 cycles in PLOT -> every point is written in order with no drops and overflow_out stays 0.

Source files
------------

// File: rtl/point_plotter_pkg.sv
// Shared screen geometry, pixel/address widths and the point payload for the plotter.
package point_plotter_pkg;

  localparam int unsigned SCREEN_WIDTH     = 320;
  localparam int unsigned SCREEN_HEIGHT    = 180;
  localparam int unsigned FB_ADDR_W        = 16;
  localparam int unsigned PIXEL_W          = 8;
  localparam int unsigned X_W              = 9;
  localparam int unsigned Y_W              = 8;
  localparam int unsigned POINT_FIFO_DEPTH = 16;

  localparam logic [PIXEL_W-1:0] FG_COLOR_DEF = 8'hFF;
  localparam logic [PIXEL_W-1:0] BG_COLOR_DEF = 8'h00;

  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } point_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PLOT
  } state_t;

  // Linear frame-buffer address of a point, row-major.
  function automatic logic [FB_ADDR_W-1:0] pixel_addr(point_t p, int unsigned w);
    return FB_ADDR_W'(FB_ADDR_W'(p.y) * FB_ADDR_W'(w)) + FB_ADDR_W'(p.x);
  endfunction

endpackage

// File: rtl/point_plotter_if.sv
// Point input stream plus frame-buffer write port and status of the point plotter.
interface point_plotter_if
  import point_plotter_pkg::*;
();

  logic [X_W-1:0]       x_in;
  logic [Y_W-1:0]       y_in;
  logic                 valid_in;
  logic                 frame_start_in;
  logic [FB_ADDR_W-1:0] fb_addr_out;
  logic [PIXEL_W-1:0]   fb_data_out;
  logic                 fb_we_out;
  logic                 busy_out;
  logic                 overflow_out;
  logic [15:0]          drop_count_out;

  modport slave (
    input  x_in, y_in, valid_in, frame_start_in,
    output fb_addr_out, fb_data_out, fb_we_out, busy_out, overflow_out, drop_count_out
  );

  modport master (
    output x_in, y_in, valid_in, frame_start_in,
    input  fb_addr_out, fb_data_out, fb_we_out, busy_out, overflow_out, drop_count_out
  );

endinterface

// File: rtl/point_fifo.sv
// Synchronous point FIFO with flush; head entry is visible combinationally.
module point_fifo
  import point_plotter_pkg::*;
#(
  parameter int unsigned DEPTH = POINT_FIFO_DEPTH
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   push_in,
  input  logic   pop_in,
  input  logic   flush_in,
  input  point_t data_in,
  output point_t head_c,
  output logic   full_c,
  output logic   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  point_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          wr_en;

  // Extra pointer bit distinguishes full from empty.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_c  = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en   = push_in && !full_c && !flush_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)             wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_in && !empty_c) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/point_plotter.sv
// Buffers projected points and writes them to the frame buffer after a per-frame background clear.
module point_plotter
  import point_plotter_pkg::*;
#(
  parameter int unsigned        WIDTH      = SCREEN_WIDTH,
  parameter int unsigned        HEIGHT     = SCREEN_HEIGHT,
  parameter int unsigned        FIFO_DEPTH = POINT_FIFO_DEPTH,
  parameter logic [PIXEL_W-1:0] FG_COLOR   = FG_COLOR_DEF,
  parameter logic [PIXEL_W-1:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  point_plotter_if.slave  bus
);

  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(WIDTH * HEIGHT - 1);

  state_t               state_q, state_d;
  logic [FB_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;
  logic [PIXEL_W-1:0]   data_q, data_d;
  logic                 we_q, we_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          drop_q, drop_d;

  logic   fifo_push, fifo_pop, fifo_flush;
  logic   fifo_full, fifo_empty;
  point_t fifo_din, fifo_head;
  logic   in_range;

  assign fifo_din = '{y: bus.y_in, x: bus.x_in};
  assign in_range = (bus.x_in < X_W'(WIDTH)) && (bus.y_in < Y_W'(HEIGHT));

  point_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (fifo_push),
    .pop_in   (fifo_pop),
    .flush_in (fifo_flush),
    .data_in  (fifo_din),
    .head_c   (fifo_head),
    .full_c   (fifo_full),
    .empty_c  (fifo_empty)
  );

  // Next-state, input acceptance and frame-buffer write generation.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    busy_d     = 1'b0;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    if (bus.frame_start_in) begin
      // New frame wins over everything, including a same-cycle point.
      fifo_flush = 1'b1;
      state_d    = ST_CLEAR;
      clr_cnt_d  = '0;
      ovf_d      = 1'b0;
      drop_d     = '0;
      busy_d     = 1'b1;
    end else begin
      if (bus.valid_in) begin
        if (!in_range || fifo_full) begin
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          if (in_range) ovf_d = 1'b1;
        end else begin
          fifo_push = 1'b1;
        end
      end

      case (state_q)
        ST_CLEAR: begin
          we_d   = 1'b1;
          addr_d = clr_cnt_q;
          data_d = BG_COLOR;
          busy_d = 1'b1;
          if (clr_cnt_q == CLR_LAST) state_d = ST_PLOT;
          else                       clr_cnt_d = clr_cnt_q + FB_ADDR_W'(1);
        end
        ST_PLOT: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            we_d     = 1'b1;
            addr_d   = pixel_addr(fifo_head, WIDTH);
            data_d   = FG_COLOR;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.fb_addr_out    = addr_q;
  assign bus.fb_data_out    = data_q;
  assign bus.fb_we_out      = we_q;
  assign bus.busy_out       = busy_q;
  assign bus.overflow_out   = ovf_q;
  assign bus.drop_count_out = drop_q;

endmodule

// File: tb/tb_point_plotter.sv
// Scoreboard bench for point_plotter: expected writes are queued by stimulus, popped by a write monitor.
module tb_point_plotter;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  point_plotter_if bus ();

  point_plotter dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Write monitor: every frame-buffer write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && bus.fb_we_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h with nothing expected at %0t",
                 bus.fb_addr_out, bus.fb_data_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.fb_addr_out), 32'(mon_e.addr));
        check("wr_data", 32'(bus.fb_data_out), 32'(mon_e.data));
        check("wr_busy", 32'(bus.busy_out), 32'(mon_e.busy));
      end
    end
  end

  task automatic send(input int x, input int y, input bit expect_wr);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b1;
    bus.x_in     = 9'(x);
    bus.y_in     = 8'(y);
    if (expect_wr) exp_q.push_back('{addr: 16'(y * 320 + x), data: 8'hFF, busy: 1'b0});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic frame_pulse(input bit with_point);
    @(posedge clk);
    #1;
    bus.frame_start_in = 1'b1;
    bus.valid_in       = with_point;
    bus.x_in           = 9'd2;
    bus.y_in           = 8'd2;
    @(posedge clk);
    #1;
    bus.frame_start_in = 1'b0;
    bus.valid_in       = 1'b0;
    exp_q.delete();
    for (int a = 0; a < 57600; a++) exp_q.push_back('{addr: 16'(a), data: 8'h00, busy: 1'b1});
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      @(posedge clk);
      c++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_addr", 32'(bus.fb_addr_out), 32'd0);
    check("rst_data", 32'(bus.fb_data_out), 32'd0);
    check("rst_we", 32'(bus.fb_we_out), 32'd0);
    check("rst_busy", 32'(bus.busy_out), 32'd0);
    check("rst_ovf", 32'(bus.overflow_out), 32'd0);
    check("rst_drop", 32'(bus.drop_count_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d writes still expected", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.x_in = '0;
    bus.y_in = '0;
    bus.valid_in = 1'b0;
    bus.frame_start_in = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    #1 rst = 1'b0;

    // Frame 1: queue three points and one bad point, then restart the frame near clear address 1000.
    frame_pulse(1'b0);
    send(1, 1, 1'b0);
    send(2, 1, 1'b0);
    send(3, 1, 1'b0);
    send(320, 5, 1'b0);
    idle();
    @(negedge clk);
    check("drop_before_restart", 32'(bus.drop_count_out), 32'd1);
    repeat (990) @(posedge clk);
    frame_pulse(1'b1);
    @(negedge clk);
    check("restart_ovf", 32'(bus.overflow_out), 32'd0);
    check("restart_drop", 32'(bus.drop_count_out), 32'd0);
    check("restart_busy", 32'(bus.busy_out), 32'd1);

    // 20 points during the clear: only the first 16 fit.
    for (int i = 0; i < 20; i++) send(100 + i, i, (i < 16));
    idle();
    @(negedge clk);
    check("clear_burst_ovf", 32'(bus.overflow_out), 32'd1);
    check("clear_burst_drop", 32'(bus.drop_count_out), 32'd4);

    drain(70000);
    @(negedge clk);
    check("plot_busy", 32'(bus.busy_out), 32'd0);
    check("plot_idle_we", 32'(bus.fb_we_out), 32'd0);

    // Two-cycle latency from point to write.
    send(10, 5, 1'b1);
    idle();
    @(negedge clk);
    check("lat_we_n1", 32'(bus.fb_we_out), 32'd0);
    @(negedge clk);
    check("lat_we_n2", 32'(bus.fb_we_out), 32'd1);
    check("lat_addr_n2", 32'(bus.fb_addr_out), 32'd1610);
    @(negedge clk);
    check("lat_single_write", 32'(bus.fb_we_out), 32'd0);
    check("lat_addr_hold", 32'(bus.fb_addr_out), 32'd1610);
    check("lat_data_hold", 32'(bus.fb_data_out), 32'd255);

    // Range boundaries.
    send(319, 179, 1'b1);
    send(320, 0, 1'b0);
    send(0, 180, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    check("range_drop", 32'(bus.drop_count_out), 32'd6);
    drain(20);

    // Back-to-back stream in PLOT.
    for (int i = 0; i < 40; i++) send(i * 7, i * 4, 1'b1);
    idle();
    drain(20);
    check("stream_drop", 32'(bus.drop_count_out), 32'd6);

    // Reset while plotting, then points in IDLE must not be written.
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_values();
    #1 rst = 1'b0;
    send(4, 4, 1'b0);
    send(5, 5, 1'b0);
    idle();
    repeat (10) @(negedge clk);
    check("idle_no_write_we", 32'(bus.fb_we_out), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
